// File: rtl/regfile16_bank.sv
// ---------------------------------------------------------------------------
// regfile16_bank
//
// Purpose:
//   16-entry register bank for the MIPS datapath. Holds the architectural
//   register state and exports every register on a flattened bus feeding the
//   downstream mux16_1 read-select stage. It also offers two combinational
//   read ports with optional same-cycle write bypass, one write port, and a
//   sequenced engine that clears the whole bank one register per cycle.
//
// Parameters:
//   WIDTH     data width of each register
//   ZERO_REG  1: register 0 reads as zero and writes to address 0 are dropped
//   BYPASS    1: read ports forward same-cycle accepted write data
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   we         write request
//   waddr      write address
//   wdata      write data
//   raddr_a    read port A address
//   raddr_b    read port B address
//   rdata_a    read port A data (combinational)
//   rdata_b    read port B data (combinational)
//   regs_flat  all registers, register i on [WIDTH*i +: WIDTH], no bypass
//   clr_req    request a full-bank clear
//   busy       high while the clear engine is running
//   clr_done   one-cycle pulse after the last register has been cleared
//   wr_drop    one-cycle pulse for each write rejected while busy
// ---------------------------------------------------------------------------
module regfile16_bank #(
    parameter int WIDTH    = 16,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [3:0]          waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [3:0]          raddr_a,
    input  logic [3:0]          raddr_b,
    output logic [WIDTH-1:0]    rdata_a,
    output logic [WIDTH-1:0]    rdata_b,
    output logic [16*WIDTH-1:0] regs_flat,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done,
    output logic                wr_drop
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [16];
    logic [WIDTH-1:0] regs_d [16];
    logic             clr_done_q, clr_done_d;
    logic             wr_drop_q, wr_drop_d;
    logic             wr_accept;

    // A write only lands while idle; address 0 is silently discarded when it
    // is hardwired, which is not treated as a drop.
    assign wr_accept = we && (state_q == ST_IDLE) &&
                       !(ZERO_REG && (waddr == 4'd0));

    // Next-state logic for the bank contents, the clear sequencer and the
    // status pulses. In IDLE a write and a clear request can coincide: the
    // write is stored now and the clear sweep wipes it afterwards. In CLEAR
    // the counter walks 0..15 and its natural wrap lines up with the return
    // to IDLE, so no trailing cycle is needed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        wr_drop_d  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    regs_d[waddr] = wdata;
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 4'd0;
                end
            end
            ST_CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 4'd1;
                wr_drop_d     = we;
                if (cnt_q == 4'd15) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers. Reset overrides everything, including an in-flight
    // clear, so an aborted sweep never produces clr_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            wr_drop_q  <= wr_drop_d;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A. Bypass piggybacks on wr_accept, which already excludes the
    // CLEAR state, so reads during a sweep see the partially cleared bank.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (BYPASS && wr_accept && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (ZERO_REG && (raddr_a == 4'd0)) begin
            rdata_a = '0;
        end
    end

    // Read port B, identical behaviour to port A.
    always_comb begin
        rdata_b = regs_q[raddr_b];
        if (BYPASS && wr_accept && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
        if (ZERO_REG && (raddr_b == 4'd0)) begin
            rdata_b = '0;
        end
    end

    // Flattened export of the registered contents for the mux16_1 stage.
    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign regs_flat[WIDTH*g +: WIDTH] = regs_q[g];
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile16_bank.sv
// ---------------------------------------------------------------------------
// tb_regfile16_bank
//
// Purpose:
//   Self-checking bench for regfile16_bank. A behavioural model tracks the
//   bank as a plain array plus a count of remaining clear cycles. Each cycle
//   the combinational read ports are checked before the clock edge and the
//   registered outputs just after it. Directed scenarios are followed by a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_regfile16_bank;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          we;
    logic [3:0]    waddr;
    logic [W-1:0]  wdata;
    logic [3:0]    raddr_a;
    logic [3:0]    raddr_b;
    logic [W-1:0]  rdata_a;
    logic [W-1:0]  rdata_b;
    logic [16*W-1:0] regs_flat;
    logic          clr_req;
    logic          busy;
    logic          clr_done;
    logic          wr_drop;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents and clear progress.
    logic [W-1:0] model_mem [16];
    int           clr_left;
    logic         exp_done;
    logic         exp_drop;

    // Observations from the most recent cycle, for scenario tallies.
    logic ob_busy;
    logic ob_done;
    logic ob_drop;

    regfile16_bank #(
        .WIDTH    (W),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .regs_flat (regs_flat),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] modelRead(input logic [3:0] ra);
        if (ra == 4'd0) return '0;
        if (clr_left == 0 && we && waddr != 4'd0 && waddr == ra) return wdata;
        return model_mem[ra];
    endfunction

    function automatic logic [255:0] modelFlat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[16*i +: 16] = model_mem[i];
        return f;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        clr_left = 0;
        exp_done = 1'b0;
        exp_drop = 1'b0;
    endtask

    // One clock cycle: drive inputs, check reads, advance the model at the
    // edge, then check the registered outputs.
    task automatic applyStimulus(input logic r, input logic w, input logic [3:0] wa,
                                 input logic [W-1:0] wd, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic cr);
        rst = r; we = w; waddr = wa; wdata = wd;
        raddr_a = ra; raddr_b = rb; clr_req = cr;
        @(negedge clk);
        checkOutput("rdata_a", rdata_a, modelRead(ra));
        checkOutput("rdata_b", rdata_b, modelRead(rb));
        @(posedge clk);
        if (r) begin
            modelReset();
        end else if (clr_left > 0) begin
            model_mem[16 - clr_left] = '0;
            clr_left--;
            exp_done = (clr_left == 0);
            exp_drop = w;
        end else begin
            exp_done = 1'b0;
            exp_drop = 1'b0;
            if (w && wa != 4'd0) model_mem[wa] = wd;
            if (cr) clr_left = 16;
        end
        #1;
        ob_busy = busy; ob_done = clr_done; ob_drop = wr_drop;
        checkOutput("regs_flat", regs_flat, modelFlat());
        checkOutput("busy", busy, clr_left > 0);
        checkOutput("clr_done", clr_done, exp_done);
        checkOutput("wr_drop", wr_drop, exp_drop);
    endtask

    task automatic idleCycle(input logic [3:0] ra, input logic [3:0] rb);
        applyStimulus(1'b0, 1'b0, 4'd0, '0, ra, rb, 1'b0);
    endtask

    task automatic fillBank(input logic [W-1:0] v);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 4'(i), v, 4'(i), 4'd0, 1'b0);
    endtask

    initial begin
        int nbusy;
        int ndone;
        int ndrop;
        int done_at;

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        @(posedge clk);
        #1;
        modelReset();

        // Reset state
        applyStimulus(1'b1, 1'b0, 4'd0, '0, 4'd3, 4'd7, 1'b0);
        checkOutput("reset_flat", regs_flat, 256'd0);
        checkOutput("reset_busy", busy, 1'b0);

        // Writes to 1..15 then read back on both ports
        for (int i = 1; i < 16; i++)
            applyStimulus(1'b0, 1'b1, 4'(i), 16'h00A0 + 16'(i), 4'(i), 4'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            idleCycle(4'(i), 4'(15 - i));
            checkOutput("t1_rdata_a", rdata_a, (i == 0) ? 16'h0 : 16'h00A0 + 16'(i));
            checkOutput("t1_slice", regs_flat[16*i +: 16], (i == 0) ? 16'h0 : 16'h00A0 + 16'(i));
        end

        // Bypass
        applyStimulus(1'b0, 1'b1, 4'd5, 16'h1111, 4'd1, 4'd2, 1'b0);
        rst = 1'b0; we = 1'b1; waddr = 4'd5; wdata = 16'h2222; raddr_a = 4'd5; raddr_b = 4'd6;
        #1;
        checkOutput("t2_bypass_a", rdata_a, 16'h2222);
        checkOutput("t2_plain_b", rdata_b, 16'h00A6);
        applyStimulus(1'b0, 1'b1, 4'd5, 16'h2222, 4'd5, 4'd6, 1'b0);
        checkOutput("t2_slice5", regs_flat[80 +: 16], 16'h2222);

        // Zero register
        applyStimulus(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0);
        checkOutput("t3_rdata0", rdata_a, 16'h0);
        checkOutput("t3_slice0", regs_flat[15:0], 16'h0);
        checkOutput("t3_drop", wr_drop, 1'b0);

        // Full clear
        fillBank(16'hBEEF);
        applyStimulus(1'b0, 1'b0, 4'd0, '0, 4'd1, 4'd2, 1'b1);
        nbusy = 0; ndone = 0; done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            idleCycle(4'(k), 4'(k + 1));
            if (ob_busy) nbusy++;
            if (ob_done) begin ndone++; done_at = k + 1; end
        end
        checkOutput("t4_busy_cycles", 32'(nbusy), 32'd15);
        checkOutput("t4_done_count", 32'(ndone), 32'd1);
        checkOutput("t4_done_latency", 32'(done_at), 32'd17);
        checkOutput("t4_all_zero", regs_flat, 256'd0);

        // Write and second clear request during a clear
        fillBank(16'hBEEF);
        applyStimulus(1'b0, 1'b0, 4'd0, '0, 4'd0, 4'd0, 1'b1);
        nbusy = 1; ndone = 0; ndrop = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 8) applyStimulus(1'b0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd3, 1'b0);
            else if (k == 10) applyStimulus(1'b0, 1'b0, 4'd0, '0, 4'd3, 4'd4, 1'b1);
            else idleCycle(4'd3, 4'd9);
            if (ob_busy) nbusy++;
            if (ob_done) ndone++;
            if (ob_drop) ndrop++;
        end
        checkOutput("t5_drop_count", 32'(ndrop), 32'd1);
        checkOutput("t5_busy_cycles", 32'(nbusy), 32'd16);
        checkOutput("t5_done_count", 32'(ndone), 32'd1);
        checkOutput("t5_reg3", regs_flat[48 +: 16], 16'h0);

        // Reset mid-clear
        fillBank(16'hBEEF);
        applyStimulus(1'b0, 1'b0, 4'd0, '0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 5; k++) idleCycle(4'd7, 4'd15);
        applyStimulus(1'b1, 1'b0, 4'd0, '0, 4'd7, 4'd15, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_flat", regs_flat, 256'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            idleCycle(4'(k), 4'd15);
            if (ob_done) ndone++;
        end
        checkOutput("t6_no_done", 32'(ndone), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic w;
            logic [3:0] wa;
            logic [3:0] ra;
            r  = ($urandom_range(0, 63) == 0);
            w  = !r && ($urandom_range(0, 1) == 1);
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
            applyStimulus(r, w, wa, 16'($urandom), ra, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile16_bank.md
Name: regfile16_bank

Overview:
- 16-entry x 16-bit register bank for the MIPS datapath. It sits directly upstream of the mux16_1 read-select stage.
- It holds architectural register state and exports all 16 registers on a flattened bus. That bus drives in0..in15 of the mux16_1 instances.
- It also provides two direct read ports with write-bypass, one write port, and a sequenced bank-clear engine.

Parameters:
- WIDTH, 16, data width of each register.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to address 0 are discarded.
- BYPASS, 1, when 1 the read ports return same-cycle accepted write data on an address match.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write request.
- waddr  input  4  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  4  read port A address.
- raddr_b  input  4  read port B address.
- rdata_a  output  WIDTH  read port A data (combinational).
- rdata_b  output  WIDTH  read port B data (combinational).
- regs_flat  output  16*WIDTH  register i on bits [WIDTH*i+WIDTH-1 : WIDTH*i]; registered contents, no bypass.
- clr_req  input  1  request a full-bank clear.
- busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_drop  output  1  one-cycle pulse when a write is rejected because the bank is busy.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All 16 registers are set to 0.
  - FSM goes to IDLE, clear counter goes to 0.
  - busy=0, clr_done=0, wr_drop=0.
  - Reset wins over every other input in the same cycle, including mid-clear: the clear aborts and no clr_done is issued.
- Write acceptance: a write is accepted when we=1, state=IDLE, and not (ZERO_REG=1 and waddr=0).
  - An accepted write updates reg[waddr] at that rising edge.
  - It is visible on regs_flat in the following cycle.
- Write to address 0 with ZERO_REG=1: silently ignored; wr_drop stays 0.
- Read ports are combinational with zero latency: rdata_x = reg[raddr_x].
  - If BYPASS=1, the write is accepted this cycle, and waddr=raddr_x, then rdata_x = wdata.
  - If ZERO_REG=1 and raddr_x=0, rdata_x = 0 always.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR: clr_req=1 at a rising edge in IDLE. Counter loads 0 and busy goes to 1 from the next cycle.
  - CLEAR: each cycle writes 0 to reg[cnt], then cnt increments. 16 cycles total (cnt 0..15).
  - CLEAR -> IDLE: at the edge where cnt=15 is cleared. busy drops to 0 and clr_done=1 for exactly the following cycle.
  - clr_req while in CLEAR is ignored; it is not queued.
  - clr_req and an accepted write in the same IDLE cycle: the write is performed, and the clear then wipes it.
- While in CLEAR:
  - we=1 is rejected and wr_drop=1 in the next cycle, one pulse per rejected cycle.
  - Bypass is disabled; reads return current register contents, which are partially cleared.
- Counter: 4-bit, wraps naturally at 15. The wrap coincides with the exit to IDLE, so no extra cycle occurs.
- Latency from clr_req to clr_done: 17 cycles (1 cycle entry + 16 clear cycles; clr_done is visible at the 17th edge).

Test Plan:
1. Reset, then write 16'h00A0+i to addresses 1..15 and read back on both ports.
   - rdata matches each value.
   - regs_flat slice i = 16'h00A0+i.
   - slice 0 = 0.
2. Bypass: reg5=16'h1111; in one cycle we=1, waddr=5, wdata=16'h2222, raddr_a=5, raddr_b=6.
   - rdata_a=16'h2222 the same cycle; rdata_b=reg6.
   - regs_flat slice 5 = 16'h2222 the next cycle.
3. Zero register: we=1, waddr=0, wdata=16'hFFFF.
   - rdata_a(raddr 0)=0.
   - regs_flat[15:0]=0.
   - wr_drop=0.
4. Clear: fill all registers with 16'hBEEF, then pulse clr_req.
   - busy=1 for 16 cycles.
   - reg[k]=0 after the k-th clear cycle.
   - clr_done pulses once, 17 cycles after clr_req.
   - all slices 0 afterwards.
5. Write during clear: we=1, waddr=3, wdata=16'h1234 at CLEAR cycle 8.
   - wr_drop pulses once.
   - reg3 stays 0 after the clear.
   - a second clr_req mid-clear does not extend busy.
6. Reset mid-clear: assert rst at CLEAR cycle 5.
   - next cycle: busy=0, all registers 0, state IDLE.
   - no clr_done pulse ever follows.
